frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter H_PIXELS, default 320, active pixels per line.
REQ-002 Parameter V_LINES, default 240, active lines per frame.
REQ-003 Parameter ADDR_W, default 17, frame-buffer address width; shall satisfy 2^ADDR_W >= H_PIXELS*V_LINES.
REQ-004 clk  input  1  camera pixel clock; all logic on posedge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 frame_enable  input  1  capture request from the frame counter, asynchronous to clk.
REQ-007 vsync  input  1  camera vertical sync, active-high.
REQ-008 href  input  1  camera line-valid, high during active bytes.
REQ-009 din  input  8  camera byte, two bytes per RGB565 pixel, high byte first.
REQ-010 we  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-011 addr  output  ADDR_W  frame-buffer write address.
REQ-012 wdata  output  16  pixel {first byte, second byte}.
REQ-013 busy  output  1  high in ARM or CAPTURE.
REQ-014 frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-015 overflow  output  1  sticky; set when pixels arrive beyond buffer capacity.

Function
REQ-016 frame_enable shall pass through a 2-flop synchronizer; only its synchronized rising edge is a capture request.
REQ-017 FSM states: IDLE, ARM, CAPTURE, DONE.
REQ-018 IDLE -> ARM on request; requests arriving outside IDLE are ignored.
REQ-019 ARM -> CAPTURE on vsync falling edge (start of frame); addr, byte phase and line count cleared on entry.
REQ-020 CAPTURE: while href high, byte phase toggles each cycle; phase-0 byte latched as high byte; on phase-1 byte, wdata={high, din} and we=1 on the next cycle.
REQ-021 addr shall hold the written pixel's address during we, then increment by 1 on the cycle after we.
REQ-022 href falling edge shall clear byte phase; a dangling phase-0 byte is discarded, no write.
REQ-023 CAPTURE -> DONE on vsync rising edge (end of frame); DONE -> IDLE after exactly one cycle with frame_done=1.
REQ-024 When written pixel count equals capacity, further writes are suppressed (we stays 0, addr holds) and overflow set; frame still completes normally.
REQ-025 vsync rising edge in ARM shall not start capture; only the falling edge does.
REQ-026 Simultaneous href falling edge and vsync rising edge: the pending pixel write (if any) completes, then DONE.

Reset
REQ-027 On reset: state IDLE, we=0, addr=0, wdata=0, busy=0, frame_done=0, overflow=0, synchronizer flops 0, byte phase 0.
REQ-028 reset mid-CAPTURE shall abort the frame with no frame_done pulse and no further writes.

Configuration
REQ-029 Macro FRAME_CAPTURE_DECIMATE_EN defined: only even pixels of even lines (0-based) are written; capacity = (H_PIXELS/2)*(V_LINES/2); addr remains contiguous.
REQ-030 Macro undefined: every complete pixel is written; capacity = H_PIXELS*V_LINES.

Verification (H_PIXELS=4, V_LINES=2, macro undefined unless stated)
REQ-031 Pulse frame_enable, vsync high->low, 2 lines of 8 bytes 0x00..0x0F, vsync high -> 8 writes, addr 0..7, wdata 0x0001,0x0203,...,0x0E0F, one frame_done, overflow=0.
REQ-032 No frame_enable, full frame driven -> we never asserted, busy=0, frame_done=0.
REQ-033 Line of 9 bytes (odd) -> 4 writes, 9th byte discarded, next line starts at high byte.
REQ-034 3 lines of 8 bytes -> writes at addr 0..7 only, overflow=1 from 9th pixel onward, frame_done pulses.
REQ-035 reset asserted after 3rd write of a frame -> outputs at reset values, no frame_done; next request captures from addr 0.
REQ-036 FRAME_CAPTURE_DECIMATE_EN defined, stimulus of REQ-031 -> 2 writes, addr 0,1, wdata 0x0001, 0x0405.

Source files
------------

// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : frame_capture
// Purpose  : Captures one RGB565 camera frame per synchronized capture request
//            and streams the pixels into a frame buffer.
// Options  : FRAME_CAPTURE_DECIMATE_EN - keep only even pixels of even lines.
// Revision : 1.0 - initial release
// ============================================================================
module frame_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

`ifdef FRAME_CAPTURE_DECIMATE_EN
    localparam int c_CAPACITY = (H_PIXELS / 2) * (V_LINES / 2);
`else
    localparam int c_CAPACITY = H_PIXELS * V_LINES;
`endif
    // One extra count state so "buffer full" is representable.
    localparam int c_CNT_W = $clog2(c_CAPACITY + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_fe_meta;
    logic                r_fe_sync;
    logic                r_fe_prev;
    logic                r_vsync_d;
    logic                r_href_d;
    logic                r_phase;
    logic [7:0]          r_hi;
    logic [c_CNT_W-1:0]  r_pix_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_overflow;
`ifdef FRAME_CAPTURE_DECIMATE_EN
    logic                r_x_odd;
    logic                r_line_odd;
`endif

    logic w_req;
    logic w_vs_fall;
    logic w_vs_rise;
    logic w_href_fall;
    logic w_full;
    logic w_keep;

    assign w_req       = r_fe_sync & ~r_fe_prev;
    assign w_vs_fall   = r_vsync_d & ~vsync;
    assign w_vs_rise   = ~r_vsync_d & vsync;
    assign w_href_fall = r_href_d & ~href;
    assign w_full      = (r_pix_cnt == c_CNT_W'(c_CAPACITY));
`ifdef FRAME_CAPTURE_DECIMATE_EN
    assign w_keep      = ~r_x_odd & ~r_line_odd;
`else
    assign w_keep      = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fe_meta    <= 1'b0;
            r_fe_sync    <= 1'b0;
            r_fe_prev    <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_href_d     <= 1'b0;
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_pix_cnt    <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
            r_x_odd      <= 1'b0;
            r_line_odd   <= 1'b0;
`endif
        end else begin
            r_fe_meta    <= frame_enable;
            r_fe_sync    <= r_fe_meta;
            r_fe_prev    <= r_fe_sync;
            r_vsync_d    <= vsync;
            r_href_d     <= href;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            // The written pixel's address is held for the strobe cycle only.
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (w_vs_fall) begin
                        r_state   <= S_CAPTURE;
                        r_addr    <= '0;
                        r_phase   <= 1'b0;
                        r_pix_cnt <= '0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        r_x_odd    <= 1'b0;
                        r_line_odd <= 1'b0;
`endif
                    end
                end
                S_CAPTURE: begin
                    if (href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_hi <= din;
                        end else begin
`ifdef FRAME_CAPTURE_DECIMATE_EN
                            r_x_odd <= ~r_x_odd;
`endif
                            if (w_keep) begin
                                if (w_full) begin
                                    r_overflow <= 1'b1;
                                end else begin
                                    r_we      <= 1'b1;
                                    r_wdata   <= {r_hi, din};
                                    r_pix_cnt <= r_pix_cnt + c_CNT_W'(1);
                                end
                            end
                        end
                    end else if (w_href_fall) begin
                        // A lone high byte at end of line is dropped here.
                        r_phase <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        r_x_odd    <= 1'b0;
                        r_line_odd <= ~r_line_odd;
`endif
                    end
                    if (w_vs_rise) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign we         = r_we;
    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_capture
// Purpose  : Self-checking bench for frame_capture (table vectors, random
//            frames vs. a pixel-list reference model, hand-written corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;
`ifdef FRAME_CAPTURE_DECIMATE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif
    localparam int CAP = DEC ? (H / 2) * (V / 2) : H * V;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_enable;
    logic          vsync;
    logic          href;
    logic [7:0]    din;
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    typedef struct {
        string       name;
        int          n;
        int          l0;
        int          l1;
        int          l2;
        bit          arm;
        int          exp_w;
        bit          exp_ovf;
        int          exp_done;
        logic [15:0] first;
        logic [15:0] last;
    } vec_t;

    wr_t        act_q[$];
    wr_t        exp_q[$];
    int         done_cnt = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] lb[3][16];
    int         ll[3];
    int         nl;

    always #5 clk = ~clk;

    frame_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .frame_enable (frame_enable),
        .vsync        (vsync),
        .href         (href),
        .din          (din),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always @(negedge clk) begin
        if (we) act_q.push_back('{a: addr, d: wdata});
        if (frame_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: walk the frame as pixel pairs and apply keep/capacity rules.
    function automatic void model_frame(input bit captured);
        int cnt = 0;
        exp_q.delete();
        if (!captured) return;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < ll[l] / 2; p++) begin
                if (DEC && ((p % 2) != 0 || (l % 2) != 0)) continue;
                if (cnt >= CAP) begin
                    m_ovf = 1'b1;
                    continue;
                end
                exp_q.push_back('{a: AW'(cnt), d: {lb[l][2*p], lb[l][2*p+1]}});
                cnt++;
            end
        end
    endfunction

    task automatic set_lines(input int n, input int a, input int b, input int c, input bit rnd);
        int k = 0;
        nl = n;
        ll[0] = a;
        ll[1] = b;
        ll[2] = c;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (l < n && i < ll[l]) begin
                    lb[l][i] = rnd ? 8'($urandom_range(255, 0)) : 8'(k);
                    k++;
                end else begin
                    lb[l][i] = 8'h00;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        frame_enable = 1'b1;
        repeat (3) @(negedge clk);
        frame_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_we"},   32'(we), 32'd0);
        check({nm, "_addr"}, 32'(addr), 32'd0);
        check({nm, "_wdata"},32'(wdata), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_done"}, 32'(frame_done), 32'd0);
        check({nm, "_ovf"},  32'(overflow), 32'd0);
    endtask

    task automatic check_frame(input string nm, input int base, input int dbase, input bit cap);
        int n_act = act_q.size() - base;
        check({nm, "_count"}, 32'(n_act), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_act) begin
                check({nm, "_addr"}, 32'(act_q[base+i].a), 32'(exp_q[i].a));
                check({nm, "_data"}, 32'(act_q[base+i].d), 32'(exp_q[i].d));
            end
        end
        check({nm, "_done"}, 32'(done_cnt - dbase), cap ? 32'd1 : 32'd0);
        check({nm, "_ovf"},  32'(overflow), 32'(m_ovf));
        check({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drive_frame(input string nm, input bit do_pulse, input bit cap, input bit sim_end);
        int base  = act_q.size();
        int dbase = done_cnt;
        model_frame(cap);
        if (do_pulse) pulse_enable();
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < ll[l]; b++) begin
                href = 1'b1;
                din  = lb[l][b];
                @(negedge clk);
            end
            href = 1'b0;
            din  = 8'h00;
            if (sim_end && l == nl - 1) vsync = 1'b1;
            repeat ($urandom_range(5, 2)) @(negedge clk);
        end
        vsync = 1'b1;
        repeat (8) @(negedge clk);
        check_frame(nm, base, dbase, cap);
    endtask

    initial begin
        vec_t tv[4];
        int   base;
        int   dbase;

        reset        = 1'b1;
        frame_enable = 1'b0;
        vsync        = 1'b1;
        href         = 1'b0;
        din          = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        tv[0] = '{"full_frame", 2, 8, 8, 0, 1'b1, DEC ? 2 : 8, 1'b0, 1,
                  16'h0001, DEC ? 16'h0405 : 16'h0E0F};
        tv[1] = '{"no_enable", 2, 8, 8, 0, 1'b0, 0, 1'b0, 0, 16'h0000, 16'h0000};
        tv[2] = '{"odd_line", 2, 9, 8, 0, 1'b1, DEC ? 2 : 8, 1'b0, 1,
                  16'h0001, DEC ? 16'h0405 : 16'h0F10};
        tv[3] = '{"overflow", 3, 8, 8, 8, 1'b1, DEC ? 2 : 8, 1'b1, 1,
                  16'h0001, DEC ? 16'h0405 : 16'h0E0F};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            set_lines(tv[v].n, tv[v].l0, tv[v].l1, tv[v].l2, 1'b0);
            base  = act_q.size();
            dbase = done_cnt;
            drive_frame(tv[v].name, tv[v].arm, tv[v].arm, 1'b0);
            check({tv[v].name, "_tbl_count"}, 32'(act_q.size() - base), 32'(tv[v].exp_w));
            check({tv[v].name, "_tbl_ovf"},   32'(overflow), 32'(tv[v].exp_ovf));
            check({tv[v].name, "_tbl_done"},  32'(done_cnt - dbase), 32'(tv[v].exp_done));
            if (tv[v].exp_w > 0 && act_q.size() - base == tv[v].exp_w) begin
                check({tv[v].name, "_first"}, 32'(act_q[base].d), 32'(tv[v].first));
                check({tv[v].name, "_last"},  32'(act_q[base + tv[v].exp_w - 1].d), 32'(tv[v].last));
            end
        end

        // Last pixel completes even when href falls together with vsync rising.
        do_reset();
        set_lines(2, 8, 8, 0, 1'b0);
        drive_frame("sim_edge", 1'b1, 1'b1, 1'b1);

        // vsync rising while armed must not start capture; extra request ignored.
        do_reset();
        @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        pulse_enable();
        pulse_enable();
        check("arm_busy", 32'(busy), 32'd1);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        base = act_q.size();
        for (int b = 0; b < 8; b++) begin
            href = 1'b1;
            din  = 8'(8'hA0 + b);
            @(negedge clk);
        end
        href = 1'b0;
        repeat (3) @(negedge clk);
        check("arm_rise_no_write", 32'(act_q.size() - base), 32'd0);
        check("arm_rise_busy", 32'(busy), 32'd1);
        set_lines(2, 8, 8, 0, 1'b1);
        drive_frame("arm_fall", 1'b0, 1'b1, 1'b0);
        drive_frame("ignored_req", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a capture aborts the frame.
        do_reset();
        set_lines(2, 8, 8, 0, 1'b0);
        base  = act_q.size();
        dbase = done_cnt;
        pulse_enable();
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 6; b++) begin
            href = 1'b1;
            din  = lb[0][b];
            @(negedge clk);
        end
        href = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_pre_writes", 32'(act_q.size() - base), 32'd3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        for (int b = 0; b < 8; b++) begin
            href = 1'b1;
            din  = lb[1][b];
            @(negedge clk);
        end
        href  = 1'b0;
        vsync = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_more_writes", 32'(act_q.size() - base), 32'd3);
        check("midrst_no_done", 32'(done_cnt - dbase), 32'd0);
        m_ovf = 1'b0;
        set_lines(2, 8, 8, 0, 1'b1);
        drive_frame("after_rst", 1'b1, 1'b1, 1'b0);

        // Random frames back to back; overflow stays sticky across them.
        for (int r = 0; r < 8; r++) begin
            bit arm_r = ($urandom_range(3, 0) != 0);
            set_lines($urandom_range(3, 1), $urandom_range(11, 2),
                      $urandom_range(11, 2), $urandom_range(11, 2), 1'b1);
            drive_frame($sformatf("rand%0d", r), arm_r, arm_r, 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
